// File: rtl/io_intr_ctrl.sv
// Synchronised I/O port plus N_IRQ-line edge-triggered interrupt controller with fixed priority and a REQ/ack/done handshake.
// Optional IRQ_OVERRUN_EN adds sticky per-line overrun flags for edges that hit an already-pending line.
module io_intr_ctrl #(
  parameter  int DATA_W      = 8,
  parameter  int N_IRQ       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              inter_en,
  input  logic              out_en,
  input  logic [DATA_W-1:0] data_from_cpu,
  output logic [DATA_W-1:0] data_to_cpu,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_data,
  input  logic              HLT_en,
  output logic              HLT_flag,
  output logic              intr_flag,
  output logic [ID_W-1:0]   intr_id,
  input  logic              intr_ack,
  input  logic              intr_done,
`ifdef IRQ_OVERRUN_EN
  output logic [N_IRQ-1:0]  overrun,
`endif
  output logic [N_IRQ-1:0]  pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_in_sync [SYNC_STAGES];
  logic [N_IRQ-1:0]  r_irq_sync [SYNC_STAGES];
  logic [N_IRQ-1:0]  r_irq_prev;
  logic [N_IRQ-1:0]  r_pending;
  logic [N_IRQ-1:0]  r_mask;
  logic [DATA_W-1:0] r_out_port;
  logic [ID_W-1:0]   r_intr_id;
  logic              r_hlt;
  state_t            r_state;

  state_t            w_state_nxt;
  logic [N_IRQ-1:0]  w_edge;
  logic [N_IRQ-1:0]  w_active;
  logic [N_IRQ-1:0]  w_clr;
  logic [ID_W-1:0]   w_win_id;
  logic              w_any;
  logic              w_enter_req;
  logic              w_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_in_sync[k]  <= '0;
        r_irq_sync[k] <= '0;
      end
      r_irq_prev <= '0;
    end else begin
      r_in_sync[0]  <= in_port;
      r_irq_sync[0] <= irq;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_in_sync[k]  <= r_in_sync[k-1];
        r_irq_sync[k] <= r_irq_sync[k-1];
      end
      r_irq_prev <= r_irq_sync[SYNC_STAGES-1];
    end
  end

  assign data_to_cpu = r_in_sync[SYNC_STAGES-1];
  assign w_edge      = r_irq_sync[SYNC_STAGES-1] & ~r_irq_prev;
  assign w_active    = r_pending & r_mask;

  // Scan high to low so the lowest active index is the one left standing.
  always_comb begin
    w_win_id = '0;
    w_any    = |w_active;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (w_active[k]) begin
        w_win_id = ID_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An ack landing in the same cycle as an enable/mask drop is honoured.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_req = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (inter_en && w_any) begin
          w_state_nxt = S_REQ;
          w_enter_req = 1'b1;
        end
      end
      S_REQ: begin
        if (intr_ack) begin
          w_state_nxt = S_SVC;
          w_ack       = 1'b1;
        end else if (!inter_en || !r_mask[r_intr_id]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SVC: begin
        if (intr_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_clr = w_ack ? (N_IRQ'(1) << r_intr_id) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= '0;
      r_mask     <= '1;
      r_intr_id  <= '0;
      r_hlt      <= 1'b0;
      r_out_port <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) begin
        r_mask <= mask_data;
      end
      if (w_enter_req) begin
        r_intr_id <= w_win_id;
      end
      if (w_enter_req) begin
        r_hlt <= 1'b0;
      end else if (HLT_en) begin
        r_hlt <= 1'b1;
      end
      if (out_en) begin
        r_out_port <= data_from_cpu;
      end
    end
  end

`ifdef IRQ_OVERRUN_EN
  logic [N_IRQ-1:0] r_overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (r_overrun & ~w_clr) | (w_edge & r_pending & ~w_clr);
    end
  end

  assign overrun = r_overrun;
`endif

  assign out_port  = r_out_port;
  assign pending   = r_pending;
  assign intr_id   = r_intr_id;
  assign intr_flag = (r_state == S_REQ);
  assign HLT_flag  = r_hlt;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Bench for io_intr_ctrl: I/O vector table, directed handshake sequences and a randomized run against a reference model.
module tb_io_intr_ctrl;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic [N-1:0]  irq;
  logic          inter_en;
  logic          out_en;
  logic [DW-1:0] data_from_cpu;
  logic [DW-1:0] data_to_cpu;
  logic          mask_we;
  logic [N-1:0]  mask_data;
  logic          HLT_en;
  logic          HLT_flag;
  logic          intr_flag;
  logic [IW-1:0] intr_id;
  logic          intr_ack;
  logic          intr_done;
  logic [N-1:0]  pending;
`ifdef IRQ_OVERRUN_EN
  logic [N-1:0]  overrun;
`endif

  io_intr_ctrl #(.DATA_W(DW), .N_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_port(in_port), .out_port(out_port), .irq(irq),
    .inter_en(inter_en), .out_en(out_en), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .mask_we(mask_we), .mask_data(mask_data),
    .HLT_en(HLT_en), .HLT_flag(HLT_flag), .intr_flag(intr_flag), .intr_id(intr_id),
    .intr_ack(intr_ack), .intr_done(intr_done),
`ifdef IRQ_OVERRUN_EN
    .overrun(overrun),
`endif
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: history of sampled inputs plus handshake phase.
  typedef enum int {M_IDLE, M_REQ, M_SVC} mphase_t;
  mphase_t       m_st;
  int            m_id;
  logic [N-1:0]  m_pend, m_mask, m_ovr;
  logic          m_hlt;
  logic [DW-1:0] m_out, m_data;
  logic [N-1:0]  q_irq[$];
  logic [DW-1:0] q_in[$];

  task automatic model_reset();
    m_st = M_IDLE; m_id = 0; m_pend = '0; m_mask = '1; m_ovr = '0;
    m_hlt = 1'b0; m_out = '0; m_data = '0;
    q_irq = {}; q_in = {};
    repeat (S + 2) q_irq.push_back('0);
    repeat (S) q_in.push_back('0);
  endtask

  task automatic step();
    logic [N-1:0] rise, clr, act;
    int           win;
    bit           enter;
    mphase_t      st_n;
    int           id_n;
    // A rise sampled S+1 edges ago reaches pending on this edge.
    q_irq.push_front(irq);
    rise = q_irq[S] & ~q_irq[S+1];
    void'(q_irq.pop_back());
    q_in.push_front(in_port);
    m_data = q_in[S-1];
    void'(q_in.pop_back());
    act = m_pend & m_mask;
    win = -1;
    for (int k = 0; k < N; k++) if (act[k] && win < 0) win = k;
    clr = '0; enter = 0; st_n = m_st; id_n = m_id;
    case (m_st)
      M_IDLE: if (inter_en && win >= 0) begin st_n = M_REQ; id_n = win; enter = 1; end
      M_REQ: begin
        if (intr_ack) begin st_n = M_SVC; clr[m_id] = 1'b1; end
        else if (!inter_en || !m_mask[m_id]) st_n = M_IDLE;
      end
      default: if (intr_done) st_n = M_IDLE;
    endcase
    m_ovr  = (m_ovr & ~clr) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = mask_data;
    if (enter) m_hlt = 1'b0;
    else if (HLT_en) m_hlt = 1'b1;
    if (out_en) m_out = data_from_cpu;
    m_st = st_n; m_id = id_n;
    @(posedge clk);
    #1;
    chk("m_out_port", out_port, m_out);
    chk("m_data_to_cpu", data_to_cpu, m_data);
    chk("m_pending", pending, m_pend);
    chk("m_intr_flag", intr_flag, m_st == M_REQ);
    chk("m_HLT_flag", HLT_flag, m_hlt);
    if (m_st == M_REQ) chk("m_intr_id", intr_id, m_id);
`ifdef IRQ_OVERRUN_EN
    chk("m_overrun", overrun, m_ovr);
`endif
  endtask

  task automatic pulse_ack();
    intr_ack = 1'b1; step(); intr_ack = 1'b0;
  endtask

  task automatic pulse_done();
    intr_done = 1'b1; step(); intr_done = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] in_v;
    logic          oe;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_out;
    logic [DW-1:0] exp_data;
  } io_vec_t;

  io_vec_t io_tab[4];

  initial begin
    io_tab[0] = '{8'hA5, 1'b1, 8'h3C, 8'h3C, 8'hA5};
    io_tab[1] = '{8'h00, 1'b0, 8'hFF, 8'h3C, 8'h00};
    io_tab[2] = '{8'hFF, 1'b1, 8'h81, 8'h81, 8'hFF};
    io_tab[3] = '{8'h5A, 1'b0, 8'h00, 8'h81, 8'h5A};

    rst = 1'b0; in_port = '0; irq = '0; inter_en = 1'b0; out_en = 1'b0;
    data_from_cpu = '0; mask_we = 1'b0; mask_data = '0; HLT_en = 1'b0;
    intr_ack = 1'b0; intr_done = 1'b0;
    model_reset();
    #3;
    chk("rst_out_port", out_port, 0);
    chk("rst_data_to_cpu", data_to_cpu, 0);
    chk("rst_pending", pending, 0);
    chk("rst_intr_flag", intr_flag, 0);
    chk("rst_intr_id", intr_id, 0);
    chk("rst_HLT_flag", HLT_flag, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      in_port = io_tab[i].in_v; out_en = io_tab[i].oe; data_from_cpu = io_tab[i].din;
      repeat (S) step();
      chk("io_out_port", out_port, io_tab[i].exp_out);
      chk("io_data_to_cpu", data_to_cpu, io_tab[i].exp_data);
    end
    out_en = 1'b0;

    // Single line, with level held high through the handshake.
    irq = 4'b0100; inter_en = 1'b1;
    step(); step();
    chk("irq2_pending_e2", pending, 4'b0000);
    step();
    chk("irq2_pending_e3", pending, 4'b0100);
    chk("irq2_flag_e3", intr_flag, 0);
    step();
    chk("irq2_flag_e4", intr_flag, 1);
    chk("irq2_id_e4", intr_id, 2);
    pulse_ack();
    chk("irq2_ack_pending", pending, 4'b0000);
    chk("irq2_ack_flag", intr_flag, 0);
    pulse_done();
    step(); step();
    chk("irq2_level_once", intr_flag, 0);
    irq = '0;
    repeat (3) step();

    // Simultaneous rises: lowest index first.
    irq = 4'b1010;
    repeat (4) step();
    chk("prio_flag", intr_flag, 1);
    chk("prio_id_first", intr_id, 1);
    pulse_ack();
    chk("prio_pending_after_ack", pending, 4'b1000);
    pulse_done();
    step();
    chk("prio_flag_second", intr_flag, 1);
    chk("prio_id_second", intr_id, 3);
    pulse_ack();
    pulse_done();
    irq = '0;
    repeat (3) step();

    // Masked line latches pending but does not request.
    mask_we = 1'b1; mask_data = 4'b1011; step(); mask_we = 1'b0;
    irq = 4'b0100;
    repeat (5) step();
    chk("mask_pending", pending, 4'b0100);
    chk("mask_no_flag", intr_flag, 0);
    mask_we = 1'b1; mask_data = 4'b1111; step(); mask_we = 1'b0;
    chk("unmask_flag_e1", intr_flag, 0);
    step();
    chk("unmask_flag_e2", intr_flag, 1);
    chk("unmask_id", intr_id, 2);
    pulse_ack();
    pulse_done();
    irq = '0;
    repeat (3) step();

    // HLT set, held while interrupts are disabled, cleared by REQ entry even against HLT_en.
    inter_en = 1'b0; HLT_en = 1'b1; step(); HLT_en = 1'b0;
    chk("hlt_set", HLT_flag, 1);
    irq = 4'b0001;
    repeat (5) step();
    chk("hlt_held_disabled", HLT_flag, 1);
    chk("hlt_no_flag", intr_flag, 0);
    chk("hlt_pending", pending, 4'b0001);
    inter_en = 1'b1; HLT_en = 1'b1; step(); HLT_en = 1'b0;
    chk("hlt_req_flag", intr_flag, 1);
    chk("hlt_cleared", HLT_flag, 0);
    chk("hlt_req_id", intr_id, 0);
    inter_en = 1'b0; step();
    chk("drop_en_flag", intr_flag, 0);
    chk("drop_en_pending", pending, 4'b0001);
    inter_en = 1'b1; step();
    chk("rereq_flag", intr_flag, 1);
    pulse_ack();
    pulse_done();
    irq = '0;
    repeat (3) step();

    // Two edges on line 0 before it is serviced.
    inter_en = 1'b0;
    irq = 4'b0001; repeat (2) step();
    irq = 4'b0000; repeat (2) step();
    irq = 4'b0001; repeat (2) step();
    irq = 4'b0000; repeat (3) step();
    chk("repeat_pending", pending, 4'b0001);
`ifdef IRQ_OVERRUN_EN
    chk("overrun_set", overrun, 4'b0001);
`endif
    inter_en = 1'b1; step();
    chk("repeat_flag", intr_flag, 1);
    pulse_ack();
    chk("repeat_ack_pending", pending, 4'b0000);
`ifdef IRQ_OVERRUN_EN
    chk("overrun_cleared", overrun, 4'b0000);
`endif
    pulse_done();

    // Asynchronous reset while in service with another line pending.
    in_port = 8'h77; out_en = 1'b1; data_from_cpu = 8'h99; irq = 4'b1010;
    repeat (4) step();
    out_en = 1'b0;
    pulse_ack();
    HLT_en = 1'b1; step(); HLT_en = 1'b0;
    chk("svc_pending_pre_rst", pending, 4'b1000);
    chk("svc_hlt_pre_rst", HLT_flag, 1);
    #3 rst = 1'b0;
    #1;
    chk("arst_out_port", out_port, 0);
    chk("arst_data_to_cpu", data_to_cpu, 0);
    chk("arst_pending", pending, 0);
    chk("arst_intr_flag", intr_flag, 0);
    chk("arst_intr_id", intr_id, 0);
    chk("arst_HLT_flag", HLT_flag, 0);
`ifdef IRQ_OVERRUN_EN
    chk("arst_overrun", overrun, 0);
`endif
    model_reset();
    irq = '0;
    #1 rst = 1'b1;
    repeat (4) step();
    chk("post_rst_idle", intr_flag, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      in_port       = DW'($urandom);
      out_en        = ($urandom_range(0, 3) == 0);
      data_from_cpu = DW'($urandom);
      mask_we       = ($urandom_range(0, 15) == 0);
      mask_data     = N'($urandom);
      inter_en      = ($urandom_range(0, 7) != 0);
      HLT_en        = ($urandom_range(0, 15) == 0);
      intr_ack      = ($urandom_range(0, 3) == 0);
      intr_done     = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_intr_ctrl.md
Name: io_intr_ctrl

Overview:
Parametrised I/O port and multi-source interrupt controller for the pipelined CPU. It provides a DATA_W-wide synchronised input port and a registered output port. It accepts N_IRQ asynchronous interrupt lines with edge detection, per-line pending latches, a software mask and fixed priority. A request/acknowledge/done handshake with the CU replaces the single intr_flag/intr_clear pair, and an interrupt releases HLT.

Parameters:
DATA_W, 8, width of in_port/out_port and CPU data paths
N_IRQ, 4, number of external interrupt lines (1..16)
SYNC_STAGES, 2, flops in each input synchroniser chain (>=2)
ID_W, $clog2(N_IRQ) (min 1), width of intr_id (localparam)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
in_port  in  DATA_W  external input port
out_port  out  DATA_W  external output port, registered
irq  in  N_IRQ  external interrupt lines, asynchronous, rising-edge events
inter_en  in  1  global interrupt enable from CU
out_en  in  1  OUT instruction write strobe
data_from_cpu  in  DATA_W  data for out_port
data_to_cpu  out  DATA_W  synchronised in_port value
mask_we  in  1  write strobe for mask register
mask_data  in  N_IRQ  new mask; bit=1 enables the line
HLT_en  in  1  CU request to halt
HLT_flag  out  1  1 while halted
intr_flag  out  1  interrupt request to CU (state REQ)
intr_id  out  ID_W  index of the requested line, valid while intr_flag=1
intr_ack  in  1  CU accepts request (1-cycle pulse)
intr_done  in  1  CU finished ISR (RTI, 1-cycle pulse)
pending  out  N_IRQ  pending latch contents, for debug/status

Behaviour:
- Reset (rst=0, async): out_port=0, data_to_cpu=0, sync chains=0, edge history=0, pending=0, mask=all 1s, HLT_flag=0, state=IDLE, intr_flag=0, intr_id=0.
- in_port: SYNC_STAGES flop chain; data_to_cpu = last stage, so latency is SYNC_STAGES clk edges.
- out_port <= data_from_cpu on edge when out_en=1; holds otherwise.
- irq[i]: SYNC_STAGES sync, then prev register. edge[i] = sync[i] & ~prev[i]. pending[i] is set on the next edge, so a rise is visible in pending after SYNC_STAGES+1 edges. Level held high produces one event only.
- pending[i] clears only on intr_ack when i==intr_id. If edge[i] occurs in that same cycle, set wins and pending stays 1. Masked lines still latch pending.
- Priority: lowest index wins among pending & mask.
- FSM, registered:
  - IDLE -> REQ when inter_en & |(pending&mask). Latches intr_id = winner and asserts intr_flag.
  - REQ: intr_id is frozen. On intr_ack -> SVC: clear pending[intr_id], deassert intr_flag. If inter_en drops, or the line becomes masked, before ack -> IDLE, intr_flag=0, pending kept.
  - SVC -> IDLE on intr_done. No nesting; new events only latch pending.
  - intr_ack outside REQ and intr_done outside SVC are ignored.
- mask write is applied on the clk edge, and IDLE evaluation uses the new mask from the following cycle.
- HLT: HLT_en sets HLT_flag. HLT_flag clears on the edge where the FSM enters REQ. If HLT_en and the REQ entry occur together, the clear wins.
- Reset mid-handshake returns to IDLE and drops all pending.

Optional Feature:
IRQ_OVERRUN_EN — when defined, adds output overrun [N_IRQ]. overrun[i] is a sticky bit set when edge[i] occurs while pending[i]=1 and no clear happens that cycle. It clears on intr_ack for line i, and resets to 0. When undefined, the port and logic are absent and repeat edges are silently merged.

Test Plan:
- Reset, then in_port=0xA5 -> data_to_cpu=0xA5 after 2 edges (SYNC_STAGES=2). out_en=1, data_from_cpu=0x3C -> out_port=0x3C next edge, held after out_en=0.
- irq[2] rises, inter_en=1 -> pending=0b0100 after 3 edges; intr_flag=1, intr_id=2 on the 4th edge. intr_ack -> pending=0, intr_flag=0. intr_done -> IDLE.
- irq[3] and irq[1] rise in the same cycle -> intr_id=1 first. After ack+done -> second REQ with intr_id=3.
- mask=0b1011, irq[2] rises -> pending[2]=1, no intr_flag. Write mask=0b1111 -> REQ intr_id=2 within 2 edges.
- HLT_en pulse -> HLT_flag=1. Then irq[0] rises with inter_en=1 -> HLT_flag=0 on the same edge intr_flag rises. With inter_en=0, HLT_flag stays 1.
- IRQ_OVERRUN_EN defined: two irq[0] edges before ack -> overrun[0]=1. intr_ack with intr_id=0 -> overrun[0]=0, pending[0]=0. Async rst asserted in SVC -> all outputs at reset values immediately.
